// File: rtl/clock_pulse_ctrl_if.sv
// Control/status bundle for clock_pulse_ctrl: start/stop handshake, run
// configuration, generated waveform, edge strobes and run status.
interface clock_pulse_ctrl_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LEN_W = 32
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] half_period;
  logic [LEN_W-1:0] run_len;
  logic             init_level;
  logic             clk_out;
  logic             edge_rise;
  logic             edge_fall;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] toggle_cnt;

  modport master (
    output start, stop, half_period, run_len, init_level,
    input  clk_out, edge_rise, edge_fall, busy, done, toggle_cnt
  );

  modport slave (
    input  start, stop, half_period, run_len, init_level,
    output clk_out, edge_rise, edge_fall, busy, done, toggle_cnt
  );
endinterface

// File: rtl/clock_pulse_ctrl.sv
// Programmable pulse generator: toggles clk_out every hp cycles for run_len
// toggles (0 = forever), with a stop request that ends on the initial level.
module clock_pulse_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LEN_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  clock_pulse_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] phase, phase_nxt;
  logic [CNT_W-1:0] hp, hp_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             lvl, lvl_nxt;
  logic             clk_q, clk_nxt;
  logic             rise_q, rise_nxt;
  logic             fall_q, fall_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             tog;
  logic             fin;
  logic [LEN_W-1:0] cnt_inc;

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    hp_nxt    = hp;
    len_nxt   = len;
    cnt_nxt   = cnt;
    lvl_nxt   = lvl;
    clk_nxt   = clk_q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    fin       = 1'b0;
    tog       = (phase == hp - CNT_W'(1));
    cnt_inc   = cnt + LEN_W'(1);

    case (state)
      IDLE: begin
        if (bus.start) begin
          hp_nxt    = (bus.half_period == '0) ? CNT_W'(1) : bus.half_period;
          len_nxt   = bus.run_len;
          lvl_nxt   = bus.init_level;
          clk_nxt   = bus.init_level;
          cnt_nxt   = '0;
          phase_nxt = '0;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end

      RUN, STOPPING: begin
        if (tog) begin
          phase_nxt = '0;
          clk_nxt   = ~clk_q;
          cnt_nxt   = cnt_inc;
          rise_nxt  = ~clk_q;
          fall_nxt  = clk_q;
        end else begin
          phase_nxt = phase + CNT_W'(1);
        end

        // Length finish wins; a stop is judged on the level after any toggle
        if (tog && (len != '0) && (cnt_inc == len)) begin
          fin = 1'b1;
        end else if (state == STOPPING) begin
          fin = tog;
        end else if (bus.stop) begin
          if (clk_nxt == lvl) fin = 1'b1;
          else                state_nxt = STOPPING;
        end

        if (fin) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      phase  <= '0;
      hp     <= '0;
      len    <= '0;
      cnt    <= '0;
      lvl    <= 1'b0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      hp     <= hp_nxt;
      len    <= len_nxt;
      cnt    <= cnt_nxt;
      lvl    <= lvl_nxt;
      clk_q  <= clk_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.clk_out    = clk_q;
  assign bus.edge_rise  = rise_q;
  assign bus.edge_fall  = fall_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.toggle_cnt = cnt;

endmodule

// File: tb/tb_clock_pulse_ctrl.sv
// Bench for clock_pulse_ctrl: directed and randomized runs checked cycle by
// cycle against an arithmetic model of the expected waveform.
module tb_clock_pulse_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        init_level;
  logic        sel;
  logic [15:0] half_period;
  logic [31:0] run_len;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  clock_pulse_ctrl_if #(.CNT_W(16), .LEN_W(32)) bus_a ();
  clock_pulse_ctrl_if #(.CNT_W(16), .LEN_W(4))  bus_b ();

  assign bus_a.start       = start & ~sel;
  assign bus_a.stop        = stop;
  assign bus_a.half_period = half_period;
  assign bus_a.run_len     = run_len;
  assign bus_a.init_level  = init_level;
  assign bus_b.start       = start & sel;
  assign bus_b.stop        = stop;
  assign bus_b.half_period = half_period;
  assign bus_b.run_len     = run_len[3:0];
  assign bus_b.init_level  = init_level;

  clock_pulse_ctrl #(.CNT_W(16), .LEN_W(32)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  clock_pulse_ctrl #(.CNT_W(16), .LEN_W(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  logic        o_clk, o_rise, o_fall, o_busy, o_done;
  logic [31:0] o_cnt;
  assign o_clk  = sel ? bus_b.clk_out   : bus_a.clk_out;
  assign o_rise = sel ? bus_b.edge_rise : bus_a.edge_rise;
  assign o_fall = sel ? bus_b.edge_fall : bus_a.edge_fall;
  assign o_busy = sel ? bus_b.busy      : bus_a.busy;
  assign o_done = sel ? bus_b.done      : bus_a.done;
  assign o_cnt  = sel ? 32'(bus_b.toggle_cnt) : bus_a.toggle_cnt;

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at k=%0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all(input int k, input logic ec, input logic er, input logic ef,
                           input logic eb, input logic ed, input logic [31:0] ecnt);
    chk("clk_out",    k, 64'(o_clk),  64'(ec));
    chk("edge_rise",  k, 64'(o_rise), 64'(er));
    chk("edge_fall",  k, 64'(o_fall), 64'(ef));
    chk("busy",       k, 64'(o_busy), 64'(eb));
    chk("done",       k, 64'(o_done), 64'(ed));
    chk("toggle_cnt", k, 64'(o_cnt),  64'(ecnt));
  endtask

  // One run: k counts edges after the start edge (k=0). The model derives the
  // finish edge td from hp, run_len and the stop edge, then the level and toggle
  // count at any k from floor(k/hp).
  task automatic run(input bit use_b, input int hp_in, input longint len_in, input bit init_in,
                     input int stop_at, input int post, input bit noise, input bit ssw,
                     input int rst_at, output int n_rise, output int n_fall);
    longint hpe, tl, td, t, ts, kk, mask, kend;
    bit     strobe, ec;
    hpe  = (hp_in == 0) ? 64'd1 : longint'(hp_in);
    mask = use_b ? 64'd15 : 64'hFFFF_FFFF;
    tl   = (len_in == 0) ? -1 : len_in * hpe;
    td   = tl;
    if (stop_at > 0 && (tl < 0 || stop_at < tl)) begin
      t  = stop_at / hpe;
      ts = (t[0] == 1'b0) ? longint'(stop_at) : (t + 1) * hpe;
      td = (tl >= 0 && tl < ts) ? tl : ts;
    end
    if (td < 0 && rst_at <= 0) begin
      $display("FAIL run_cfg: unbounded run requested");
      $fatal(1);
    end
    kend   = (rst_at > 0) ? longint'(rst_at) : td + longint'(post);
    n_rise = 0;
    n_fall = 0;
    sel         = use_b;
    start       = 1'b1;
    stop        = ssw;
    half_period = 16'(hp_in);
    run_len     = 32'(len_in);
    init_level  = init_in;
    for (longint k = 0; k <= kend; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (rst_at > 0 && k == longint'(rst_at)) begin
        check_all(int'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      end else begin
        kk     = (td >= 0 && k > td) ? td : k;
        t      = kk / hpe;
        ec     = init_in ^ t[0];
        strobe = (k > 0) && (td < 0 || k <= td) && (k % hpe == 0);
        check_all(int'(k), ec, strobe & ec, strobe & ~ec, (td < 0) || (k < td), k == td,
                  32'(t & mask));
      end
      n_rise += int'(o_rise);
      n_fall += int'(o_fall);
      start = 1'b0;
      stop  = 1'b0;
      reset = 1'b0;
      if (noise) begin
        half_period = 16'($urandom);
        run_len     = $urandom;
        init_level  = 1'($urandom);
        if ((td < 0 || k < td) && $urandom_range(0, 3) == 0) start = 1'b1;
      end
      if (stop_at > 0 && k + 1 == longint'(stop_at)) stop = 1'b1;
      else if (noise && ((stop_at > 0 && k + 1 > longint'(stop_at)) || (td >= 0 && k + 1 > td))
               && $urandom_range(0, 2) == 0) stop = 1'b1;
      if (rst_at > 0 && k + 1 == longint'(rst_at)) reset = 1'b1;
    end
    start = 1'b0;
    stop  = 1'b0;
    if (rst_at > 0) begin
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check_all(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    end
  endtask

  initial begin
    int     nr, nf, hp, sa;
    longint ln;
    bit     ub;
    reset       = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    sel         = 1'b0;
    init_level  = 1'b0;
    half_period = '0;
    run_len     = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    sel = 1'b1;
    check_all(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    sel   = 1'b0;
    reset = 1'b0;

    // Stop in IDLE leaves everything untouched
    stop = 1'b1;
    @(posedge clock);
    @(negedge clock);
    stop = 1'b0;
    check_all(-2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Nominal 300-toggle run at hp=20 starting high
    run(1'b0, 20, 300, 1'b1, 0, 5, 1'b0, 1'b0, 0, nr, nf);
    chk("rise_count", 0, 64'(nr), 64'd150);
    chk("fall_count", 0, 64'(nf), 64'd150);

    // Zero half-period behaves as one
    run(1'b0, 0, 4, 1'b0, 0, 3, 1'b1, 1'b0, 0, nr, nf);

    // Early stops while high and while already at the initial level
    run(1'b0, 5, 0, 1'b0, 7, 3, 1'b1, 1'b0, 0, nr, nf);
    run(1'b0, 5, 0, 1'b0, 12, 3, 1'b1, 1'b0, 0, nr, nf);

    // Start together with stop in IDLE
    run(1'b0, 2, 6, 1'b1, 0, 2, 1'b1, 1'b1, 0, nr, nf);

    // Stop coinciding with the final toggle
    run(1'b0, 3, 4, 1'b0, 12, 2, 1'b0, 1'b0, 0, nr, nf);

    // Reset at the 10th toggle, then a clean run
    run(1'b0, 3, 100, 1'b0, 0, 0, 1'b1, 1'b0, 30, nr, nf);
    run(1'b0, 3, 5, 1'b1, 0, 3, 1'b1, 1'b0, 0, nr, nf);

    // Narrow counter wraps in a forever run, ended by a stop
    run(1'b1, 1, 0, 1'b0, 37, 4, 1'b1, 1'b0, 0, nr, nf);

    for (int i = 0; i < 12; i++) begin
      ub = 1'($urandom_range(0, 1));
      hp = int'($urandom_range(0, 6));
      ln = longint'($urandom_range(0, 24));
      if (ub) ln = ln & 64'd15;
      sa = ($urandom_range(0, 1) == 1 || ln == 0) ? int'($urandom_range(1, 60)) : 0;
      run(ub, hp, ln, 1'($urandom_range(0, 1)), sa, 3, 1'b1, 1'($urandom_range(0, 1)), 0, nr, nf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
